// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared width, opcode and state types for the iterative multiply/divide unit
package mdu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring-division step on unsigned magnitudes
module mdu_divstep
  import mdu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;
  logic [W:0] diff;
  logic       ge;

  // rem_i[W] is always clear in practice; folding it into ge keeps the compare exact anyway
  always_comb begin
    shifted = {rem_i[W-1:0], quo_i[W-1]};
    diff    = shifted - {1'b0, dvs_i};
    ge      = rem_i[W] | (shifted >= {1'b0, dvs_i});
    rem_o   = ge ? diff : shifted;
    quo_o   = {quo_i[W-2:0], ge};
  end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit with a fixed 34-cycle start-to-done latency
module mdu_iter
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q;
  mdu_op_e           op_q;
  logic [4:0]        count_q;
  logic [XLEN-1:0]   opnd_q, a_raw_q, result_q, result_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic              neg_q, rneg_q, div0_q, ovf_q, busy_q, done_q;

  mdu_op_e           op_in;
  logic              a_sgn, b_sgn, is_div;
  logic [XLEN-1:0]   a_mag, b_mag;

  always_comb begin
    op_in  = mdu_op_e'(funct3);
    is_div = funct3[2];
    a_sgn  = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & a[XLEN-1];
    b_sgn  = (op_in inside {OP_MULH, OP_DIV, OP_REM}) & b[XLEN-1];
    a_mag  = a_sgn ? -a : a;
    b_mag  = b_sgn ? -b : b;
  end

  // Multiply: prod_q holds {partial high, multiplier bits still to consume}.
  // Divide: prod_q[XLEN-1:0] shifts dividend bits out and quotient bits in.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_step;
  logic [XLEN-1:0] quo_step;

  mdu_divstep #(.W(XLEN)) u_divstep (
    .rem_i (rem_q),
    .quo_i (prod_q[XLEN-1:0]),
    .dvs_i (opnd_q),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  always_comb begin
    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    prod_d  = {mul_sum, prod_q[XLEN-1:1]};
    rem_d   = rem_q;
    if (op_q[2]) begin
      prod_d = {prod_q[2*XLEN-1:XLEN], quo_step};
      rem_d  = rem_step;
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_fix  = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    case (op_q)
      OP_MUL:                       result_d = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result_d = div0_q ? {XLEN{1'b1}} : (ovf_q ? INT_MIN : quo_fix);
      default:                      result_d = div0_q ? a_raw_q : (ovf_q ? {XLEN{1'b0}} : rem_fix);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      count_q  <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (start) begin
            op_q    <= op_in;
            opnd_q  <= is_div ? b_mag : a_mag;
            prod_q  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            rem_q   <= '0;
            a_raw_q <= a;
            neg_q   <= a_sgn ^ b_sgn;
            rneg_q  <= a_sgn;
            div0_q  <= (b == '0);
            ovf_q   <= is_div & a_sgn & (a == INT_MIN) & (b == {XLEN{1'b1}});
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          prod_q  <= prod_d;
          rem_q   <= rem_d;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          result_q <= result_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking scoreboard bench for mdu_iter
`timescale 1ns/1ps
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mdu_iter dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xs, xu, ys, yu, p;
    int          sx, sy;
    xs = {{32{x[31]}}, x};
    xu = {32'b0, x};
    ys = {{32{y[31]}}, y};
    yu = {32'b0, y};
    sx = x;
    sy = y;
    p  = '0;
    case (f)
      3'd0: begin p = xu * yu; return p[31:0]; end
      3'd1: begin p = xs * ys; return p[63:32]; end
      3'd2: begin p = xs * yu; return p[63:32]; end
      3'd3: begin p = xu * yu; return p[63:32]; end
      3'd4: if (y == 0) return 32'hFFFF_FFFF;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
            else return 32'(sx / sy);
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: if (y == 0) return x;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
            else return 32'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Called at a negedge; returns one negedge after the accepting clock edge.
  task automatic issue(input string name, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] res);
    exp_t e;
    funct3 = f;
    a      = x;
    b      = y;
    start  = 1'b1;
    e.name = name;
    e.res  = res;
    exp_q.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    funct3 = 3'($urandom);
  endtask

  task automatic wait_done(input int k0, output int lat, output int bc);
    lat = k0;
    bc  = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  f[4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] x[4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] y[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] r[4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue($sformatf("mul%0d", i), f[i], x[i], y[i], r[i]);
      wait_done(1, lat, bc);
      e = exp_q.pop_front();
      n_checks++;
      if (done !== 1'b1 || lat != 34) begin
        n_fail++;
        $display("FAIL %s latency: done=%b at cycle %0d, required done=1 at 34", e.name, done, lat);
      end
      n_checks++;
      if (result !== e.res) begin
        n_fail++;
        $display("FAIL %s result: got %h, required %h", e.name, result, e.res);
      end
      n_checks++;
      if (bc != 33) begin
        n_fail++;
        $display("FAIL %s busy_cycles: got %0d, required 33", e.name, bc);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done_width: done=%b one cycle later, required 0", e.name, done);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f[10] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] x[10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'd5, 32'd5,
                           32'h8000_0000, 32'h8000_0000};
    logic [31:0] y[10] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] r[10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                           32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      issue($sformatf("div%0d", i), f[i], x[i], y[i], r[i]);
      wait_done(1, lat, bc);
      e = exp_q.pop_front();
      n_checks++;
      if (done !== 1'b1 || lat != 34 || bc != 33) begin
        n_fail++;
        $display("FAIL %s latency: done=%b at cycle %0d busy %0d, required done=1 at 34 busy 33",
                 e.name, done, lat, bc);
      end
      n_checks++;
      if (result !== e.res) begin
        n_fail++;
        $display("FAIL %s result: got %h, required %h", e.name, result, e.res);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] pool[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd3};
    logic [31:0] x, y;
    logic [2:0]  f;
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 24; i++) begin
      f = 3'(i % 8);
      x = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      issue($sformatf("rnd%0d_f%0d_%h_%h", i, f, x, y), f, x, y, model(f, x, y));
      wait_done(1, lat, bc);
      e = exp_q.pop_front();
      n_checks++;
      if (done !== 1'b1 || result !== e.res) begin
        n_fail++;
        $display("FAIL %s: done=%b result %h, required done=1 result %h", e.name, done, result, e.res);
      end
    end
  endtask

  task automatic test_handshake();
    int lat, bc;
    int stray;
    exp_t e;
    issue("hs_divu", 3'd5, 32'd100, 32'd7, 32'd14);
    repeat (4) @(negedge clk);
    start = 1'b1; funct3 = 3'd0; a = 32'd1000; b = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat, bc);
    e = exp_q.pop_front();
    n_checks++;
    if (done !== 1'b1 || lat != 34) begin
      n_fail++;
      $display("FAIL %s latency: done=%b at cycle %0d, required done=1 at 34", e.name, done, lat);
    end
    n_checks++;
    if (result !== e.res) begin
      n_fail++;
      $display("FAIL %s result: got %h, required %h", e.name, result, e.res);
    end
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL hs_ignored_start: %0d busy/done cycles after completion, required 0", stray);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    exp_t e;
    issue("b2b_first", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    wait_done(1, lat, bc);
    e = exp_q.pop_front();
    n_checks++;
    if (done !== 1'b1 || result !== e.res) begin
      n_fail++;
      $display("FAIL %s: done=%b result %h, required done=1 result %h", e.name, done, result, e.res);
    end
    issue("b2b_second", 3'd0, 32'd3, 32'd4, 32'd12);
    wait_done(1, lat, bc);
    e = exp_q.pop_front();
    n_checks++;
    if (done !== 1'b1 || lat != 34 || bc != 33) begin
      n_fail++;
      $display("FAIL %s latency: done=%b at cycle %0d busy %0d, required done=1 at 34 busy 33",
               e.name, done, lat, bc);
    end
    n_checks++;
    if (result !== e.res) begin
      n_fail++;
      $display("FAIL %s result: got %h, required %h", e.name, result, e.res);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    int stray;
    exp_t e;
    issue("rst_abort", 3'd4, 32'd1000, 32'd3, 32'd333);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_state: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    e = exp_q.pop_back();
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rst_no_done: %0d busy/done cycles after aborted op, required 0", stray);
    end
    issue("rst_divu", 3'd5, 32'd9, 32'd3, 32'd3);
    wait_done(1, lat, bc);
    e = exp_q.pop_front();
    n_checks++;
    if (done !== 1'b1 || lat != 34 || result !== e.res) begin
      n_fail++;
      $display("FAIL %s: done=%b at cycle %0d result %h, required done=1 at 34 result %h",
               e.name, done, lat, result, e.res);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_random();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected results left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
